// File: rtl/peripheral_dbg_soc_osd_event_pkg.sv
// Shared types for the OSD event packetizer.
//   state_e : packetizer FSM states. Each non-IDLE state names the flit
//             currently presented on out_data.
//   entry_t : one captured event, timestamp zero-extended to 16 bits plus
//             the 32-bit event word.
package peripheral_dbg_soc_osd_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEST,
        SRC,
        TYPE,
        TS,
        DLO,
        DHI
    } state_e;

    localparam logic [15:0] TYPE_EVENT   = 16'h0000;
    localparam int          TYPE_OVF_BIT = 15;

    typedef struct packed {
        logic [15:0] ts;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/peripheral_dbg_soc_osd_event_fifo.sv
// Synchronous event FIFO with registered read data.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full)
//   wdata    : entry to store
//   pop      : move head entry into rdata (ignored when empty)
//   rdata    : registered head entry, valid from the cycle after a pop and
//              held until the next pop (doubles as the packet holding reg)
//   full     : DEPTH entries stored
//   empty    : no entries stored
module peripheral_dbg_soc_osd_event_fifo
    import peripheral_dbg_soc_osd_event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      rdata_q, rdata_d;
    entry_t      mem_q [DEPTH];
    logic        do_push, do_pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign rdata = rdata_q;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rdata_d  = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/peripheral_dbg_soc_osd_event_packetizer.sv
// Trace event packetizer: captures {timestamp, ev_data} per event into a
// small FIFO and serializes each entry as a 6-flit debug-NoC packet
// (DEST, SRC, TYPE, TS, DATA lo, DATA hi). Events on a full FIFO are dropped.
//   clk, rst   : clock, synchronous active-high reset
//   timestamp  : live counter value (WIDTH bits, zero-extended into a flit)
//   ev_valid   : one event per cycle high
//   ev_data    : 32-bit event payload
//   out_data   : 16-bit flit
//   out_valid  : flit valid
//   out_last   : last flit of packet
//   out_ready  : sink accepts flit
// Build option OSD_EVENT_OVERFLOW_REPORT_EN: keeps a saturating 15-bit drop
// count and, from IDLE, emits a 4-flit overflow packet
// (DEST, SRC, TYPE={1,count}, TS) before the next queued event.
module peripheral_dbg_soc_osd_event_packetizer
    import peripheral_dbg_soc_osd_event_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] MOD_ID     = 16'h0000,
    parameter logic [15:0] DEST_ID    = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] timestamp,
    input  logic             ev_valid,
    input  logic [31:0]      ev_data,
    output logic [15:0]      out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    state_e      state_q, state_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;

    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    entry_t      fifo_wdata, hold;
    logic [15:0] ts_ext;
    logic        xfer, start;

    // Per-packet flit contents that differ between event and overflow packets.
    logic        ovf_pkt;
    logic [15:0] type_word, ts_word;

    always_comb begin
        ts_ext = '0;
        ts_ext[WIDTH-1:0] = timestamp;
    end

    assign fifo_wdata = '{ts: ts_ext, data: ev_data};
    // Fullness is the pre-pop value, so a push on a full FIFO is dropped
    // even when IDLE pops in the same cycle.
    assign fifo_push  = ev_valid && !fifo_full;
    assign xfer       = out_valid_q && out_ready;

    peripheral_dbg_soc_osd_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (hold),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef OSD_EVENT_OVERFLOW_REPORT_EN
    logic        is_ovf_q, is_ovf_d;
    logic [15:0] ovf_ts_q, ovf_ts_d;
    logic [14:0] drop_cnt_q, drop_cnt_d;
    logic        drop;
    logic [15:0] ovf_type;

    assign drop    = ev_valid && fifo_full;
    assign ovf_pkt = is_ovf_q;

    always_comb begin
        ovf_type = {1'b0, drop_cnt_q};
        ovf_type[TYPE_OVF_BIT] = 1'b1;
    end

    // The count is captured into the TYPE flit when SRC transfers.
    assign type_word = is_ovf_q ? ovf_type : TYPE_EVENT;
    assign ts_word   = is_ovf_q ? ovf_ts_q : hold.ts;

    // Cleared when the reporting TYPE flit leaves; a drop in that same
    // cycle starts the next count at 1.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (state_q == TYPE && xfer && is_ovf_q)
            drop_cnt_d = {14'd0, drop};
        else if (drop && drop_cnt_q != 15'h7FFF)
            drop_cnt_d = drop_cnt_q + 15'd1;
    end
`else
    assign ovf_pkt   = 1'b0;
    assign type_word = TYPE_EVENT;
    assign ts_word   = hold.ts;
`endif

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        fifo_pop    = 1'b0;
        start       = 1'b0;
`ifdef OSD_EVENT_OVERFLOW_REPORT_EN
        is_ovf_d    = is_ovf_q;
        ovf_ts_d    = ovf_ts_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef OSD_EVENT_OVERFLOW_REPORT_EN
                if (drop_cnt_q != '0) begin
                    start    = 1'b1;
                    is_ovf_d = 1'b1;
                    ovf_ts_d = ts_ext;
                end else if (!fifo_empty) begin
                    start    = 1'b1;
                    fifo_pop = 1'b1;
                    is_ovf_d = 1'b0;
                end
`else
                if (!fifo_empty) begin
                    start    = 1'b1;
                    fifo_pop = 1'b1;
                end
`endif
                if (start) begin
                    state_d     = DEST;
                    out_valid_d = 1'b1;
                    out_data_d  = DEST_ID;
                    out_last_d  = 1'b0;
                end
            end
            DEST: if (xfer) begin
                state_d    = SRC;
                out_data_d = MOD_ID;
            end
            SRC: if (xfer) begin
                state_d    = TYPE;
                out_data_d = type_word;
            end
            TYPE: if (xfer) begin
                state_d    = TS;
                out_data_d = ts_word;
                out_last_d = ovf_pkt;
            end
            TS: if (xfer) begin
                if (ovf_pkt) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_last_d  = 1'b0;
                end else begin
                    state_d    = DLO;
                    out_data_d = hold.data[15:0];
                end
            end
            DLO: if (xfer) begin
                state_d    = DHI;
                out_data_d = hold.data[31:16];
                out_last_d = 1'b1;
            end
            DHI: if (xfer) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_last_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef OSD_EVENT_OVERFLOW_REPORT_EN
            is_ovf_q    <= 1'b0;
            ovf_ts_q    <= '0;
            drop_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef OSD_EVENT_OVERFLOW_REPORT_EN
            is_ovf_q    <= is_ovf_d;
            ovf_ts_q    <= ovf_ts_d;
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_event_packetizer.sv
// Self-checking bench for the OSD event packetizer. Directed scenarios check
// exact flit streams; a random phase compares every cycle against a
// queue-based packet model. Define OSD_EVENT_OVERFLOW_REPORT_EN for both the
// RTL and this bench to exercise overflow reporting.
module tb_peripheral_dbg_soc_osd_event_packetizer;

    localparam int          D   = 4;
    localparam logic [15:0] DID = 16'h00D5;
    localparam logic [15:0] MID = 16'h0A5A;
`ifdef OSD_EVENT_OVERFLOW_REPORT_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ts = '0;
    logic        ev_valid = 1'b0;
    logic [31:0] ev_data = '0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid, out_last;

    always #5 clk = ~clk;

    peripheral_dbg_soc_osd_event_packetizer #(
        .WIDTH(16), .FIFO_DEPTH(D), .MOD_ID(MID), .DEST_ID(DID)
    ) dut (
        .clk(clk), .rst(rst), .timestamp(ts), .ev_valid(ev_valid), .ev_data(ev_data),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] got_d[$];
    bit          got_l[$];
    logic [15:0] exp_d[$];
    bit          exp_l[$];

    // ---------------- reference model: queues of events and flits ----------
    typedef struct { logic [15:0] t; logic [31:0] d; } ev_t;
    ev_t         mq[$];
    logic [15:0] md[$];
    bit          ml[$];
    int          m_cnt;
    bit          m_ovf;
    int          m_pos;
    logic [15:0] exp_data;
    logic        exp_valid, exp_last;

    always @(posedge clk) begin
        bit  full, drop, clr;
        ev_t e;
        if (rst) begin
            mq.delete(); md.delete(); ml.delete();
            m_cnt = 0; m_ovf = 0; m_pos = 0;
        end else begin
            full = (mq.size() == D);
            drop = ev_valid && full;
            clr  = 0;
            if (md.size() == 0) begin
                m_pos = 0;
                if (OVF && m_cnt != 0) begin
                    m_ovf = 1;
                    md = {DID, MID, 16'h0000, ts};
                    ml = {1'b0, 1'b0, 1'b0, 1'b1};
                end else if (mq.size() != 0) begin
                    e = mq.pop_front();
                    m_ovf = 0;
                    md = {DID, MID, 16'h0000, e.t, e.d[15:0], e.d[31:16]};
                    ml = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                end
            end else if (out_ready) begin
                if (m_ovf && m_pos == 2) clr = 1;
                void'(md.pop_front());
                void'(ml.pop_front());
                m_pos++;
                // overflow TYPE reports the count as it stands when SRC leaves
                if (m_ovf && m_pos == 2) md[0] = 16'h8000 | 16'(m_cnt);
            end
            if (ev_valid && !full) mq.push_back('{ts, ev_data});
            if (clr) m_cnt = int'(drop);
            else if (drop && m_cnt < 32767) m_cnt++;
        end
        exp_valid = (md.size() != 0);
        exp_data  = exp_valid ? md[0] : 16'h0000;
        exp_last  = exp_valid ? ml[0] : 1'b0;
    end

    // Records flits that transfer at each upcoming edge; no checking here.
    task automatic step_collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            @(negedge clk);
        end
    endtask

    task automatic add_ev_pkt(input logic [15:0] t, input logic [31:0] d);
        exp_d.push_back(DID); exp_d.push_back(MID); exp_d.push_back(16'h0000);
        exp_d.push_back(t); exp_d.push_back(d[15:0]); exp_d.push_back(d[31:16]);
        for (int i = 0; i < 6; i++) exp_l.push_back(i == 5);
    endtask

    task automatic test_reset();
        rst = 1; ev_valid = 1; ev_data = 32'h1111_2222; out_ready = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 16'h0) $display("FAIL reset_data got %h want 0000", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_last got %b want 0", out_last); else n_pass++;
        rst = 0; ev_valid = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_fifo_empty got valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_single();
        int first = -1;
        exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
        out_ready = 1;
        ts = 16'h0042; ev_data = 32'hDEADBEEF; ev_valid = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ev_valid = 0;
            if (out_valid && first < 0) first = k;
            if (out_valid && out_ready) begin got_d.push_back(out_data); got_l.push_back(out_last); end
        end
        n_checks++; if (first !== 2) $display("FAIL single_latency got %0d want 2", first); else n_pass++;
        add_ev_pkt(16'h0042, 32'hDEADBEEF);
        n_checks++; if (got_d.size() !== 6) $display("FAIL single_count got %0d want 6", got_d.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                $display("FAIL single_flit%0d got %h/%b want %h/%b", i,
                         (i < got_d.size()) ? got_d[i] : 16'hxxxx, (i < got_l.size()) ? got_l[i] : 1'b0, exp_d[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [15:0] pd;
        logic        pv, pr, pl;
        exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
        out_ready = 1; pv = 0; pr = 1; pd = 0; pl = 0;
        ts = 16'h0042; ev_data = 32'hDEADBEEF; ev_valid = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ev_valid = 0;
            if (pv && !pr) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)
                    $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b", out_valid, out_data, out_last, pd, pl);
                else n_pass++;
            end
            out_ready = ~out_ready;
            if (out_valid && out_ready) begin got_d.push_back(out_data); got_l.push_back(out_last); end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
        out_ready = 1;
        add_ev_pkt(16'h0042, 32'hDEADBEEF);
        n_checks++; if (got_d.size() !== 6) $display("FAIL stall_count got %0d want 6", got_d.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                $display("FAIL stall_flit%0d got %h want %h", i, (i < got_d.size()) ? got_d[i] : 16'hxxxx, exp_d[i]);
            else n_pass++;
        end
    endtask

    // Back-to-back events into a stalled sink: the first is popped into the
    // holding register, D more fill the FIFO, the rest are dropped.
    task automatic test_overflow();
        int n_ev, kept, drops;
        n_ev  = OVF ? 8 : 7;
        kept  = D + 1;
        drops = n_ev - kept;
        exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
        out_ready = 0;
        @(negedge clk);
        for (int i = 0; i < n_ev; i++) begin
            ts = 16'h0100 + 16'(i); ev_data = 32'hA5000000 + 32'(i); ev_valid = 1;
            @(negedge clk);
        end
        ev_valid = 0; ts = 16'h0777;
        repeat (3) @(negedge clk);
        out_ready = 1;
        step_collect(80);
        add_ev_pkt(16'h0100, 32'hA5000000);
        if (OVF) begin
            exp_d.push_back(DID); exp_d.push_back(MID);
            exp_d.push_back(16'h8000 | 16'(drops)); exp_d.push_back(16'h0777);
            for (int i = 0; i < 4; i++) exp_l.push_back(i == 3);
        end
        for (int i = 1; i < kept; i++) add_ev_pkt(16'h0100 + 16'(i), 32'hA5000000 + 32'(i));
        n_checks++;
        if (got_d.size() !== exp_d.size()) $display("FAIL ovf_flit_count got %0d want %0d", got_d.size(), exp_d.size());
        else n_pass++;
        for (int i = 0; i < exp_d.size(); i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                $display("FAIL ovf_flit%0d got %h/%b want %h/%b", i,
                         (i < got_d.size()) ? got_d[i] : 16'hxxxx, (i < got_l.size()) ? got_l[i] : 1'b0, exp_d[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit hit = 0;
        exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
        out_ready = 1;
        ts = 16'h0011; ev_data = 32'h12345678; ev_valid = 1;
        for (int k = 0; k < 30 && !hit; k++) begin
            @(negedge clk);
            ev_valid = 0;
            if (out_valid && n == 3) begin
                hit = 1;
                n_checks++; if (out_data !== 16'h0011) $display("FAIL rstmid_ts_flit got %h want 0011", out_data); else n_pass++;
                rst = 1;
            end else if (out_valid && out_ready) n++;
        end
        n_checks++; if (!hit) $display("FAIL rstmid_timeout got no TS flit within 30 cycles want TS flit"); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'h0)
            $display("FAIL rstmid_abandon got %b/%h/%b want 0/0000/0", out_valid, out_data, out_last);
        else n_pass++;
        rst = 0;
        @(negedge clk);
        ts = 16'h0022; ev_data = 32'hCAFEF00D; ev_valid = 1;
        @(negedge clk);
        ev_valid = 0;
        step_collect(20);
        add_ev_pkt(16'h0022, 32'hCAFEF00D);
        n_checks++; if (got_d.size() !== 6) $display("FAIL rstmid_count got %0d want 6", got_d.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                $display("FAIL rstmid_flit%0d got %h want %h", i, (i < got_d.size()) ? got_d[i] : 16'hxxxx, exp_d[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int rdy_pct;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== exp_valid || out_data !== exp_data || out_last !== exp_last)
                $display("FAIL random_cyc%0d got %b/%h/%b want %b/%h/%b", i,
                         out_valid, out_data, out_last, exp_valid, exp_data, exp_last);
            else n_pass++;
            rdy_pct   = ((i / 100) % 2) ? 85 : 20;
            ev_valid  = ($urandom_range(0, 99) < 40);
            ts        = 16'($urandom);
            ev_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        ev_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
